// File: rtl/mmio_responder.sv
// I/O-page responder for the CPU data bus: LED register, UART status and an
// 8N1 UART transmitter. Read data is registered, one cycle after the strobe.
module mmio_responder #(
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int BAUD        = 115200
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] MEM_ADDR,
  input  logic [31:0] MEM_WDATA,
  input  logic [3:0]  MEM_WSTRB,
  input  logic        MEM_RSTRB,
  output logic [31:0] mem_rdata,
  output logic [4:0]  LEDS,
  output logic        TXD,
  output logic        uart_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  tx_state_t        state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  logic        io_sel;
  logic [2:0]  reg_sel;
  logic        led_we;
  logic        tx_start;
  logic        bit_done;
  logic [31:0] rd_val;

  assign io_sel   = MEM_ADDR[22];
  assign reg_sel  = MEM_ADDR[4:2];
  assign led_we   = io_sel & reg_sel[0] & MEM_WSTRB[0];
  assign tx_start = io_sel & reg_sel[1] & MEM_WSTRB[0] & ~uart_busy;
  assign bit_done = (bit_cnt == CNT_LAST);

  // UART_DATA reads as zero, so only LEDS and status contribute to the OR.
  assign rd_val = ({27'b0, LEDS} & {32{reg_sel[0]}})
                | ({22'b0, uart_busy, 9'b0} & {32{reg_sel[2]}});

  logic unused_bits;
  assign unused_bits = ^{MEM_ADDR[31:23], MEM_ADDR[21:5], MEM_ADDR[1:0],
                         MEM_WDATA[31:8], MEM_WSTRB[3:1]};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      LEDS      <= '0;
      mem_rdata <= '0;
    end else begin
      if (led_we) LEDS <= MEM_WDATA[4:0];
      if (MEM_RSTRB && io_sel) mem_rdata <= rd_val;
    end
  end

  // Shift register is pure data: it is loaded on every accepted write.
  always_ff @(posedge CLK) begin
    if (tx_start)
      shift <= MEM_WDATA[7:0];
    else if (state == DATA && bit_done)
      shift <= {1'b0, shift[7:1]};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      TXD       <= 1'b1;
      uart_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          bit_idx <= '0;
          if (tx_start) begin
            state     <= START;
            TXD       <= 1'b0;
            uart_busy <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            state   <= DATA;
            bit_cnt <= '0;
            bit_idx <= '0;
            TXD     <= shift[0];
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              TXD   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              TXD     <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            uart_busy <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          TXD       <= 1'b1;
          uart_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: directed and random bus traffic against a
// timeline model of the LED register, read port and UART frame.
module tb_mmio_responder;

  localparam int CLK_HZ = 4_000_000;
  localparam int BAUD_R = 1_000_000;
  localparam int CPB    = CLK_HZ / BAUD_R;
  localparam int FRAME  = 10 * CPB;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_rstrb = 1'b0;
  logic [31:0] mem_rdata;
  logic [4:0]  LEDS;
  logic        TXD;
  logic        uart_busy;

  mmio_responder #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .MEM_WSTRB(mem_wstrb), .MEM_RSTRB(mem_rstrb), .mem_rdata(mem_rdata),
    .LEDS(LEDS), .TXD(TXD), .uart_busy(uart_busy)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Model: an accepted frame is a byte plus the edge it started on.
  int          e = 0;
  int          start_e = 0;
  logic        active = 1'b0;
  logic [7:0]  fbyte = '0;
  logic [4:0]  m_leds = '0;
  logic [31:0] m_rdata = '0;

  function automatic logic m_busy();
    return active && ((e - start_e) < FRAME);
  endfunction

  function automatic logic m_txd();
    int idx;
    if (!m_busy()) return 1'b1;
    idx = (e - start_e) / CPB;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return fbyte[idx-1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_bus(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic r);
    mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_rstrb = r;
  endtask

  task automatic idle_bus();
    set_bus(32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic tick();
    logic pre_busy;
    @(posedge CLK);
    pre_busy = m_busy();
    if (mem_rstrb && mem_addr[22])
      m_rdata = (mem_addr[2] ? {27'b0, m_leds} : 32'h0) |
                ((mem_addr[4] && pre_busy) ? 32'h200 : 32'h0);
    if (mem_addr[22] && mem_addr[2] && mem_wstrb[0]) m_leds = mem_wdata[4:0];
    e++;
    if (mem_addr[22] && mem_addr[3] && mem_wstrb[0] && !pre_busy) begin
      active = 1'b1; start_e = e; fbyte = mem_wdata[7:0];
    end
    #1;
    chk("leds", LEDS, m_leds);
    chk("rdata", mem_rdata, m_rdata);
    chk("txd", TXD, m_txd());
    chk("busy", uart_busy, m_busy());
  endtask

  task automatic do_reset();
    #2 RESET = 1'b1;
    #1;
    active = 1'b0; m_leds = '0; m_rdata = '0;
    chk("rst_leds", LEDS, 0);
    chk("rst_txd", TXD, 1);
    chk("rst_busy", uart_busy, 0);
    chk("rst_rdata", mem_rdata, 0);
    repeat (2) begin
      @(posedge CLK); #1;
      chk("rst_hold_txd", TXD, 1);
    end
    RESET = 1'b0;
  endtask

  // Called right after the accepting edge with the bus idle.
  task automatic watch(input logic [9:0] seq, output int cnt);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      if (!uart_busy) break;
      if (k % CPB == CPB / 2) chk("txd_bit", TXD, seq[k/CPB]);
      cnt++;
      tick();
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (!uart_busy) break;
      tick();
    end
    chk("drained", uart_busy, 0);
  endtask

  initial begin
    int cnt;
    logic [31:0] a;
    idle_bus();
    do_reset();
    tick();

    // LED write, read, and write with only WSTRB[1]
    set_bus(32'h0040_0004, 32'h0000_0015, 4'b0001, 1'b0); tick();
    chk("led_wr", LEDS, 32'h15);
    set_bus(32'h0040_0004, 32'h0, 4'b0000, 1'b1); tick();
    chk("led_rd", mem_rdata, 32'h0000_0015);
    set_bus(32'h0040_0004, 32'h0000_000A, 4'b0010, 1'b0); tick();
    chk("led_wstrb1", LEDS, 32'h15);

    // UART frame 0xA5
    set_bus(32'h0040_0008, 32'h0000_00A5, 4'b0001, 1'b0); tick();
    idle_bus();
    watch(10'b1101001010, cnt);
    chk("a5_busy_len", cnt, 40);

    // Write while busy is dropped; status read returns busy
    set_bus(32'h0040_0008, 32'h0000_0041, 4'b0001, 1'b0); tick();
    idle_bus();
    cnt = 1;
    repeat (19) begin tick(); cnt++; end
    set_bus(32'h0040_0018, 32'h0000_0042, 4'b0001, 1'b1); tick(); cnt++;
    chk("status_busy", mem_rdata, 32'h0000_0200);
    idle_bus();
    for (int k = 0; k < 100; k++) begin
      if (!uart_busy) break;
      tick(); cnt++;
    end
    chk("drop_busy_len", cnt - 1, 40);
    set_bus(32'h0040_0010, 32'h0, 4'b0000, 1'b1); tick();
    chk("status_idle", mem_rdata, 32'h0);

    // Write on the last stop-bit cycle is dropped; the next one is accepted
    set_bus(32'h0040_0008, 32'h0000_0043, 4'b0001, 1'b0); tick();
    idle_bus();
    repeat (39) tick();
    set_bus(32'h0040_0008, 32'h0000_0044, 4'b0001, 1'b0); tick();
    chk("last_cycle_drop", uart_busy, 0);
    set_bus(32'h0040_0008, 32'h0000_0045, 4'b0001, 1'b0); tick();
    chk("back_to_back", uart_busy, 1);
    idle_bus();
    watch({1'b1, 8'h45, 1'b0}, cnt);
    chk("b2b_busy_len", cnt, 40);

    // Outside the I/O page nothing changes
    set_bus(32'h0000_0004, 32'h0000_001F, 4'b0001, 1'b1); tick();
    chk("decode_leds", LEDS, 32'h15);
    chk("decode_rdata", mem_rdata, 32'h0);

    // Reset mid-frame, then a clean frame
    set_bus(32'h0040_0008, 32'h0000_0033, 4'b0001, 1'b0); tick();
    idle_bus();
    repeat (14) tick();
    do_reset();
    tick();
    set_bus(32'h0040_0008, 32'h0000_0055, 4'b0001, 1'b0); tick();
    idle_bus();
    watch({1'b1, 8'h55, 1'b0}, cnt);
    chk("post_rst_len", cnt, 40);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      a = $urandom;
      a[4:2] = 3'($urandom_range(0, 7));
      a[22] = ($urandom_range(0, 3) != 0);
      set_bus(a, $urandom, ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0,
              1'($urandom));
      tick();
    end
    idle_bus();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
